// File: rtl/pm1_exponent_gen.sv
// rtl/pm1_exponent_gen.sv - p-1 exponent generator, E = lcm(1..B) via trial-division primes
// Optional trace outputs pp_valid/pp_value enabled by defining PM1_EXP_TRACE_EN.
module pm1_exponent_gen #(
   parameter int BOUND_W = 8,
   parameter int E_W     = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [BOUND_W-1:0] boundary,
   output logic               busy,
   output logic               done,
   output logic [E_W-1:0]     e,
`ifdef PM1_EXP_TRACE_EN
   output logic               pp_valid,
   output logic [BOUND_W-1:0] pp_value,
`endif
   output logic               overflow
);

   localparam int P_W   = E_W + BOUND_W;
   localparam int CNT_W = $clog2(BOUND_W + 1);
   localparam int W2    = 2 * BOUND_W;

   typedef enum logic [2:0] {
      S_IDLE, S_NEXT_CAND, S_PRIME_TEST, S_POWER, S_MULT, S_DONE
   } state_t;

   state_t state, state_next;

   logic [BOUND_W-1:0] bound;
   logic [BOUND_W:0]   cand;
   logic [BOUND_W-1:0] d;
   logic [BOUND_W-1:0] q;
   logic [E_W-1:0]     acc;
   logic [P_W-1:0]     prod;
   logic [P_W-1:0]     mcand;
   logic [BOUND_W-1:0] qsh;
   logic [CNT_W-1:0]   mcnt;

   // Wide compares so that neither d*d nor q*cand can wrap.
   logic [W2-1:0]    dd;
   logic [W2-1:0]    pw;
   logic [BOUND_W:0] rem;
   logic [P_W-1:0]   psum;
   logic             cand_gt_b;
   logic             is_prime;
   logic             is_comp;
   logic             pw_fits;
   logic             mult_last;

   assign dd        = W2'(d) * W2'(d);
   assign pw        = W2'(q) * W2'(cand);
   assign rem       = cand % {1'b0, d};
   assign psum      = prod + (qsh[0] ? mcand : '0);
   assign cand_gt_b = cand > {1'b0, bound};
   assign is_prime  = dd > W2'(cand);
   assign is_comp   = rem == '0;
   assign pw_fits   = pw <= W2'(bound);
   assign mult_last = mcnt == CNT_W'(BOUND_W - 1);

   assign busy = (state != S_IDLE) && (state != S_DONE);
   assign done = state == S_DONE;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   // Next-state decode.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_next = S_NEXT_CAND;
         S_NEXT_CAND:    state_next = cand_gt_b ? S_DONE : S_PRIME_TEST;
         S_PRIME_TEST: begin
            if (is_prime)     state_next = S_POWER;
            else if (is_comp) state_next = S_NEXT_CAND;
         end
         S_POWER:        if (!pw_fits) state_next = S_MULT;
         S_MULT:         if (mult_last) state_next = S_NEXT_CAND;
         default:        state_next = S_IDLE;
      endcase
   end

   // Datapath: candidate search, prime power build-up and shift-add multiply.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bound    <= '0;
         cand     <= '0;
         d        <= '0;
         q        <= '0;
         acc      <= '0;
         prod     <= '0;
         mcand    <= '0;
         qsh      <= '0;
         mcnt     <= '0;
         e        <= E_W'(1);
         overflow <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  bound    <= boundary;
                  acc      <= E_W'(1);
                  cand     <= (BOUND_W + 1)'(2);
                  overflow <= 1'b0;
               end
            end
            S_NEXT_CAND: begin
               d <= BOUND_W'(2);
               if (cand_gt_b) e <= acc;
            end
            S_PRIME_TEST: begin
               if (is_prime)     q    <= cand[BOUND_W-1:0];
               else if (is_comp) cand <= cand + 1'b1;
               else              d    <= d + 1'b1;
            end
            S_POWER: begin
               if (pw_fits) begin
                  q <= pw[BOUND_W-1:0];
               end else begin
                  prod  <= '0;
                  mcand <= P_W'(acc);
                  qsh   <= q;
                  mcnt  <= '0;
               end
            end
            S_MULT: begin
               prod  <= psum;
               mcand <= mcand << 1;
               qsh   <= qsh >> 1;
               mcnt  <= mcnt + 1'b1;
               if (mult_last) begin
                  acc      <= psum[E_W-1:0];
                  overflow <= overflow | (|psum[P_W-1:E_W]);
                  cand     <= cand + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef PM1_EXP_TRACE_EN
   // Report each prime power on the edge that enters MULT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pp_valid <= 1'b0;
         pp_value <= '0;
      end else begin
         pp_valid <= (state == S_POWER) && !pw_fits;
         if ((state == S_POWER) && !pw_fits) pp_value <= q;
      end
   end
`endif

endmodule

// File: tb/tb_pm1_exponent_gen.sv
// tb/tb_pm1_exponent_gen.sv - directed self-checking bench for pm1_exponent_gen
module tb_pm1_exponent_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  boundary = 8'd0;
   logic        busy;
   logic        done;
   logic [63:0] e;
   logic        overflow;
`ifdef PM1_EXP_TRACE_EN
   logic        pp_valid;
   logic [7:0]  pp_value;
   logic [7:0]  pp_q[$];
`endif

   int n_cmp = 0;
   int n_err = 0;
   int cyc;

   always #5 clk = ~clk;

   pm1_exponent_gen #(.BOUND_W(8), .E_W(64)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .boundary (boundary),
      .busy     (busy),
      .done     (done),
      .e        (e),
`ifdef PM1_EXP_TRACE_EN
      .pp_valid (pp_valid),
      .pp_value (pp_value),
`endif
      .overflow (overflow)
   );

`ifdef PM1_EXP_TRACE_EN
   always @(negedge clk) if (pp_valid) pp_q.push_back(pp_value);
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Entered and left at posedge+1; pulses start and waits for done.
   task automatic run(input logic [7:0] b, output int cycles);
      boundary = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cycles = 1;
      while (!done && cycles < 20000) begin
         @(posedge clk); #1;
         cycles++;
      end
      check("done_seen", {63'd0, done}, 64'd1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_e", e, 64'd1);
      check("rst_ovf", {63'd0, overflow}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: B=13
`ifdef PM1_EXP_TRACE_EN
      pp_q.delete();
`endif
      run(8'd13, cyc);
      check("b13_e", e, 64'd360360);
      check("b13_ovf", {63'd0, overflow}, 64'd0);
      check("b13_busy", {63'd0, busy}, 64'd0);
`ifdef PM1_EXP_TRACE_EN
      begin
         logic [7:0] exp_pp[6] = '{8'd8, 8'd9, 8'd5, 8'd7, 8'd11, 8'd13};
         check("pp_count", 64'(pp_q.size()), 64'd6);
         for (int i = 0; i < 6 && i < pp_q.size(); i++)
            check("pp_value", {56'd0, pp_q[i]}, {56'd0, exp_pp[i]});
      end
`endif

      // 2: B=10 then B=1 back-to-back
      run(8'd10, cyc);
      check("b10_e", e, 64'd2520);
      run(8'd1, cyc);
      check("b1_e", e, 64'd1);
      check("b1_ovf", {63'd0, overflow}, 64'd0);
      check("b1_lat_le3", {63'd0, (cyc <= 3)}, 64'd1);

      // 3: B=46 fits, B=47 overflows
      run(8'd46, cyc);
      check("b46_e", e, 64'd9419588158802421600);
      check("b46_ovf", {63'd0, overflow}, 64'd0);
      run(8'd47, cyc);
      check("b47_ovf", {63'd0, overflow}, 64'd1);
      check("b47_done", {63'd0, done}, 64'd1);

      // 4: maximum bound
      run(8'd255, cyc);
      check("b255_ovf", {63'd0, overflow}, 64'd1);

      // 5: start while busy is ignored
      boundary = 8'd13;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("busy_mid", {63'd0, busy}, 64'd1);
      boundary = 8'd5;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 20000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("ign_done", {63'd0, done}, 64'd1);
      check("ign_e", e, 64'd360360);

      // 5b: asynchronous reset mid-run
      run(8'd4, cyc);
      boundary = 8'd13;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_busy", {63'd0, busy}, 64'd0);
      check("arst_done", {63'd0, done}, 64'd0);
      check("arst_e", e, 64'd1);
      check("arst_ovf", {63'd0, overflow}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 6: small bounds
      run(8'd2, cyc);
      check("b2_e", e, 64'd2);
      run(8'd4, cyc);
      check("b4_e", e, 64'd12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
